// File: rtl/pulse_event_arbiter_if.sv
// Event handshake bundle between pulse_event_arbiter and its consumer.
//   evt_valid : producer -> consumer, an event is on offer
//   evt_ready : consumer -> producer, the offered event is taken this cycle
//   evt_ch    : producer -> consumer, channel index of the offered event
interface pulse_event_arbiter_if #(
    parameter int NCH = 4
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;

    modport master (
        output evt_valid,
        output evt_ch,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        output evt_ready
    );
endinterface

// File: rtl/pulse_event_arbiter.sv
// Rising-edge event collector with round-robin hand-off.
// Each channel counts enabled rising edges of its level input into a
// saturating pending counter; a two-state arbiter offers one pending event
// at a time on the evt bundle, starting its scan after the last granted
// channel.
//   clk     : clock, all state on rising edge
//   rstn    : asynchronous active-low reset
//   x       : per-channel level inputs
//   en      : per-channel edge-capture enable
//   ovf_clr : clears all sticky overflow flags
//   ovf     : sticky per-channel pending-count overflow flags
//   busy    : an event is on offer or some channel has pending events
//   evt     : event handshake (master side)
module pulse_event_arbiter #(
    parameter int NCH   = 4,
    parameter int CNT_W = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NCH-1:0]         x,
    input  logic [NCH-1:0]         en,
    input  logic                   ovf_clr,
    output logic [NCH-1:0]         ovf,
    output logic                   busy,
    pulse_event_arbiter_if.master  evt
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        S_IDLE,
        S_OFFER
    } state_t;

    state_t          r_state;
    logic            r_evt_valid;
    logic [CH_W-1:0] r_evt_ch;
    logic [CH_W-1:0] r_last_grant;
    logic [NCH-1:0]  r_x_q;
    logic [NCH-1:0]  r_ovf;
    logic [CNT_W-1:0] r_cnt [NCH];

    logic [NCH-1:0]  w_inc;
    logic [NCH-1:0]  w_dec;
    logic [NCH-1:0]  w_sat;
    logic [NCH-1:0]  w_nz;
    logic [NCH-1:0]  w_ovf_set;
    logic            w_hs;
    logic            w_sel_found;
    logic [CH_W-1:0] w_sel_ch;

    assign w_hs = r_evt_valid & evt.evt_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign w_inc[gi]     = x[gi] & ~r_x_q[gi] & en[gi];
            assign w_dec[gi]     = w_hs & (r_evt_ch == CH_W'(gi));
            assign w_sat[gi]     = &r_cnt[gi];
            assign w_nz[gi]      = |r_cnt[gi];
            // A decrement in the same cycle frees a slot, so no overflow then.
            assign w_ovf_set[gi] = w_inc[gi] & w_sat[gi] & ~w_dec[gi];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_cnt[gi] <= '0;
                end else if (w_inc[gi] && !w_dec[gi] && !w_sat[gi]) begin
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
                end else if (!w_inc[gi] && w_dec[gi]) begin
                    r_cnt[gi] <= r_cnt[gi] - 1'b1;
                end
            end
        end
    endgenerate

    // Edge history resets to ones so a line already high at release is not
    // mistaken for a fresh edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_x_q <= '1;
            r_ovf <= '0;
        end else begin
            r_x_q <= x;
            r_ovf <= (r_ovf & ~{NCH{ovf_clr}}) | w_ovf_set;
        end
    end

    // Cyclic scan from last_grant+1; the extra index bit keeps the sum from
    // wrapping before the modulo-NCH correction.
    always_comb begin
        logic [CH_W:0] w_idx;
        w_sel_found = 1'b0;
        w_sel_ch    = '0;
        w_idx       = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_idx = {1'b0, r_last_grant} + (CH_W+1)'(k);
            if (w_idx >= (CH_W+1)'(NCH)) begin
                w_idx = w_idx - (CH_W+1)'(NCH);
            end
            if (!w_sel_found && w_nz[w_idx[CH_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_ch    = w_idx[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_evt_valid  <= 1'b0;
            r_evt_ch     <= '0;
            r_last_grant <= CH_W'(NCH - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel_found) begin
                        r_evt_ch    <= w_sel_ch;
                        r_evt_valid <= 1'b1;
                        r_state     <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    // Always return to IDLE after a grant, which spaces
                    // accepted events at least two cycles apart.
                    if (evt.evt_ready) begin
                        r_evt_valid  <= 1'b0;
                        r_last_grant <= r_evt_ch;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_evt_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign evt.evt_valid = r_evt_valid;
    assign evt.evt_ch    = r_evt_ch;
    assign ovf           = r_ovf;
    assign busy          = r_evt_valid | (|w_nz);
endmodule

// File: tb/tb_pulse_event_arbiter.sv
module tb_pulse_event_arbiter;
    logic       clk;
    logic       rstn;
    logic [3:0] x;
    logic [3:0] en;
    logic       ovf_clr;
    logic [3:0] ovf;
    logic       busy;

    int n_checks;
    int n_fail;
    int cyc;
    int last_hs;
    int exp_q[$];

    pulse_event_arbiter_if #(.NCH(4)) evt_if ();

    pulse_event_arbiter #(.NCH(4), .CNT_W(3)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .x       (x),
        .en      (en),
        .ovf_clr (ovf_clr),
        .ovf     (ovf),
        .busy    (busy),
        .evt     (evt_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] m);
        x = x | m;
        tick();
        x = x & ~m;
        tick();
    endtask

    task automatic apply_reset(input logic [3:0] xv);
        rstn = 1'b0;
        x = xv;
        last_hs = -1;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        while ((exp_q.size() != 0 || busy) && b < 100) begin
            tick();
            b++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, {31'd0, busy}, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        last_hs  = -1;
        rstn     = 1'b0;
        x        = 4'h0;
        en       = 4'hF;
        ovf_clr  = 1'b0;
        evt_if.evt_ready = 1'b0;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                if (rstn && evt_if.evt_valid && evt_if.evt_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL grant: got unexpected ch %0d expected no grant", evt_if.evt_ch);
                    end else begin
                        int e;
                        e = exp_q.pop_front();
                        if (int'(evt_if.evt_ch) != e) begin
                            n_fail++;
                            $display("FAIL grant: got ch %0d expected ch %0d", evt_if.evt_ch, e);
                        end else begin
                            $display("grant ch=%0d cycle=%0d", evt_if.evt_ch, cyc);
                        end
                    end
                    if (last_hs >= 0) begin
                        n_checks++;
                        if (cyc - last_hs < 2) begin
                            n_fail++;
                            $display("FAIL grant_gap: got %0d cycles expected >= 2", cyc - last_hs);
                        end
                    end
                    last_hs = cyc;
                end
            end
        join_none

        // Reset state, checked while reset is still asserted.
        #1;
        check("rst_valid", {31'd0, evt_if.evt_valid}, 0);
        check("rst_ch", {30'd0, evt_if.evt_ch}, 0);
        check("rst_ovf", {28'd0, ovf}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        tick();
        rstn = 1'b1;
        tick();

        // Single pulse latency on channel 0.
        evt_if.evt_ready = 1'b1;
        x = 4'b0001;
        exp_q.push_back(0);
        tick();
        check("pulse_busy_n", {31'd0, busy}, 1);
        check("pulse_valid_n", {31'd0, evt_if.evt_valid}, 0);
        tick();
        check("pulse_valid_n1", {31'd0, evt_if.evt_valid}, 1);
        check("pulse_ch_n1", {30'd0, evt_if.evt_ch}, 0);
        tick();
        check("pulse_valid_n2", {31'd0, evt_if.evt_valid}, 0);
        check("pulse_busy_n2", {31'd0, busy}, 0);
        x = 4'b0000;
        drain("pulse");

        // Round-robin from reset, then resume after last grant (3).
        apply_reset(4'b0000);
        evt_if.evt_ready = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        pulse(4'b1111);
        drain("rr_all");
        exp_q.push_back(1);
        exp_q.push_back(2);
        pulse(4'b0110);
        drain("rr_pair");

        // Backpressure on channel 2 with three more edges during the offer.
        apply_reset(4'b0000);
        evt_if.evt_ready = 1'b0;
        pulse(4'b0100);
        check("bp_valid", {31'd0, evt_if.evt_valid}, 1);
        check("bp_ch", {30'd0, evt_if.evt_ch}, 2);
        for (int c = 0; c < 10; c++) begin
            x[2] = (c % 2 == 0) && (c < 6);
            tick();
            if (!evt_if.evt_valid || evt_if.evt_ch != 2'd2)
                check("bp_hold", {29'd0, evt_if.evt_valid, evt_if.evt_ch}, 3'b110);
        end
        check("bp_hold_end", {29'd0, evt_if.evt_valid, evt_if.evt_ch}, 3'b110);
        x = 4'b0000;
        repeat (4) exp_q.push_back(2);
        evt_if.evt_ready = 1'b1;
        drain("bp");

        // Saturation and overflow on channel 1.
        apply_reset(4'b0000);
        evt_if.evt_ready = 1'b0;
        repeat (7) pulse(4'b0010);
        check("sat_ovf_7", {28'd0, ovf}, 0);
        pulse(4'b0010);
        check("sat_ovf_8", {28'd0, ovf}, 4'b0010);
        x = 4'b0010;
        ovf_clr = 1'b1;
        tick();
        check("sat_clr_set_wins", {28'd0, ovf}, 4'b0010);
        x = 4'b0000;
        tick();
        check("sat_clr", {28'd0, ovf}, 0);
        ovf_clr = 1'b0;
        repeat (7) exp_q.push_back(1);
        evt_if.evt_ready = 1'b1;
        drain("sat");

        // Input high through reset release, and disabled channel.
        apply_reset(4'b0001);
        evt_if.evt_ready = 1'b1;
        tick();
        tick();
        check("rsthi_busy", {31'd0, busy}, 0);
        check("rsthi_valid", {31'd0, evt_if.evt_valid}, 0);
        en = 4'b1101;
        pulse(4'b0010);
        tick();
        check("en_off_busy", {31'd0, busy}, 0);
        check("en_off_valid", {31'd0, evt_if.evt_valid}, 0);
        en = 4'hF;
        x = 4'b0000;
        tick();

        // Reset asserted during an offer with pending counts [2,1,0,0].
        apply_reset(4'b0000);
        evt_if.evt_ready = 1'b0;
        pulse(4'b0011);
        pulse(4'b0001);
        check("mid_valid", {31'd0, evt_if.evt_valid}, 1);
        check("mid_ch", {30'd0, evt_if.evt_ch}, 0);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        last_hs = -1;
        #1;
        check("mid_rst_valid", {31'd0, evt_if.evt_valid}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_ch", {30'd0, evt_if.evt_ch}, 0);
        tick();
        rstn = 1'b1;
        tick();
        check("mid_post_busy", {31'd0, busy}, 0);
        evt_if.evt_ready = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(3);
        pulse(4'b1001);
        drain("mid_post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pulse_event_arbiter.md
PULSE_EVENT_ARBITER -- requirements
Module: pulse_event_arbiter

Interface
REQ-001 Parameter NCH, default 4: number of monitored level inputs, 2..8.
REQ-002 Parameter CNT_W, default 3: per-channel pending-count width; saturation value 2^CNT_W-1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 x  input  NCH  synchronous level inputs, one per channel.
REQ-006 en  input  NCH  per-channel edge-capture enable.
REQ-007 evt_valid  output  1  event offered on evt_ch.
REQ-008 evt_ready  input  1  consumer accepts offered event.
REQ-009 evt_ch  output  clog2(NCH)  index of offered channel.
REQ-010 ovf  output  NCH  sticky per-channel pending-count overflow flags.
REQ-011 ovf_clr  input  1  clears all ovf bits.
REQ-012 busy  output  1  high when state is OFFER or any pending count is nonzero.

Function
REQ-013 Each channel SHALL keep a registered previous sample x_q[i], loaded with x[i] every cycle.
REQ-014 Rising edge on channel i SHALL be x[i]=1 and x_q[i]=0 at the same clock edge.
REQ-015 Edge with en[i]=1 SHALL increment cnt[i] at that clock edge; en[i]=0 SHALL discard the edge.
REQ-016 en[i]=0 SHALL NOT clear cnt[i]; pending events remain eligible for arbitration.
REQ-017 Simultaneous increment and decrement on one channel SHALL leave cnt[i] unchanged.
REQ-018 Edge with cnt[i] saturated and no same-cycle decrement: cnt[i] holds, ovf[i] sets next edge.
REQ-019 ovf_clr=1 SHALL clear all ovf bits; same-cycle new overflow SHALL set that bit (set wins).
REQ-020 Arbiter FSM, states IDLE and OFFER; evt_valid=1 exactly in OFFER.
REQ-021 IDLE: if any cnt nonzero, select first nonzero channel scanning upward cyclically from last_grant+1 (mod NCH), register it to evt_ch, go OFFER.
REQ-022 IDLE with all cnt zero SHALL remain IDLE; evt_ch holds its previous value.
REQ-023 OFFER: evt_valid and evt_ch SHALL hold stable until evt_ready=1, regardless of x, en or other counts.
REQ-024 Handshake (OFFER and evt_ready=1): cnt[evt_ch] decrements, last_grant<=evt_ch, go IDLE.
REQ-025 Peak throughput SHALL be one accepted event per two cycles; no back-to-back OFFER.
REQ-026 evt_ready while in IDLE SHALL be ignored.
REQ-027 Latency: x[i] sampled 0 at edge n-1, 1 at edge n, FSM idle, no pending -> cnt[i]=1 after edge n, evt_valid=1 after edge n+1.
REQ-028 Edges arriving during OFFER SHALL be counted and not lost (below saturation).

Reset
REQ-029 rstn=0 SHALL immediately force: state IDLE, evt_valid=0, evt_ch=0, cnt all 0, ovf all 0, busy=0.
REQ-030 Reset SHALL load x_q to all ones, so an input already high at reset release generates no event.
REQ-031 Reset SHALL load last_grant=NCH-1, giving channel 0 first priority.
REQ-032 Reset asserted during OFFER SHALL drop the offered and all pending events without a handshake.

Verification
REQ-033 Single pulse: x[0] 0->1 at edge n, evt_ready=1 -> evt_valid=1, evt_ch=0 after edge n+1; cnt[0]=0 and evt_valid=0 after edge n+2.
REQ-034 Round-robin: x[3:0] all rise same edge, evt_ready=1 -> grants 0,1,2,3 at two-cycle spacing; then x[1],x[2] rise -> order 1,2.
REQ-035 Backpressure: evt_ready=0 for 10 cycles in OFFER with ch2, three more x[2] edges -> evt_ch stable at 2; then cnt[2]=3 after accept.
REQ-036 Saturation, CNT_W=3, evt_ready=0: 8 x[1] edges -> cnt[1]=7, ovf[1]=1; ovf_clr with simultaneous 9th edge -> ovf[1] stays 1.
REQ-037 Enable and reset-high: x[0]=1 through reset release -> no event; en[1]=0 with x[1] edge -> cnt[1]=0, no grant.
REQ-038 Reset mid-operation: rstn low during OFFER with cnt=[2,1,0,0] -> evt_valid=0 immediately, all cnt 0; after release next grant is channel 0.
